// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests and runs the exception freeze/flush handshake.
// Optional stall watchdog enabled with the CTRL_WATCHDOG_EN macro.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE  = 32'h0000000E,
  parameter int          WDT_LIMIT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] mem_excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
`ifdef CTRL_WATCHDOG_EN
  output logic        stall_timeout,
`endif
  output logic [31:0] new_pc
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        accept_s;

  assign accept_s = (state_q == ST_RUN) && (mem_excepttype != 32'd0) && !stallreq_mem;

  // State, flush and redirect registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      flush_q  <= 1'b0;
      new_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Next-state logic and redirect capture
  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_RUN: begin
        if (accept_s) begin
          state_d  = ST_FREEZE;
          new_pc_d = (mem_excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
        end else begin
          state_d  = ST_RUN;
          new_pc_d = 32'd0;
        end
      end
      ST_FREEZE: state_d = ST_FLUSH;
      ST_FLUSH: begin
        state_d  = ST_RUN;
        new_pc_d = 32'd0;
      end
      default: begin
        state_d  = ST_RUN;
        new_pc_d = 32'd0;
      end
    endcase
  end

  // Output logic: stall vector from state and requests; flush pulses in the cycle after FREEZE
  always_comb begin
    stall   = 6'b000000;
    flush_d = (state_q == ST_FREEZE);
    if (!rst) begin
      stall = 6'b000000;
    end else begin
      case (state_q)
        ST_RUN: begin
          // accept and mem stall both hold the faulting/waiting instruction out of WB
          if (accept_s || stallreq_mem) stall = 6'b011111;
          else if (stallreq_ex)         stall = 6'b001111;
          else if (stallreq_id)         stall = 6'b000111;
          else if (stallreq_if)         stall = 6'b000011;
          else                          stall = 6'b000000;
        end
        ST_FREEZE: stall = 6'b011111;
        ST_FLUSH:  stall = 6'b000000;
        default:   stall = 6'b000000;
      endcase
    end
  end

  assign flush  = flush_q;
  assign new_pc = new_pc_q;

`ifdef CTRL_WATCHDOG_EN
  localparam int             CW      = $clog2(WDT_LIMIT + 1);
  localparam logic [CW-1:0]  WDT_MAX = CW'(WDT_LIMIT);

  logic [CW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic          timeout_q, timeout_d;

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Saturating count of consecutive RUN cycles with the PC stalled
  always_comb begin
    if ((state_q == ST_RUN) && stall[0]) begin
      wdt_cnt_d = (wdt_cnt_q == WDT_MAX) ? wdt_cnt_q : wdt_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      wdt_cnt_d = '0;
    end
    timeout_d = timeout_q | (wdt_cnt_d == WDT_MAX);
  end

  assign stall_timeout = timeout_q;
`endif

endmodule
